// File: rtl/varlat_bank_arb.sv
// Round-robin arbiter from NumIn requesters onto one bank port, with in-order response routing via an ID FIFO.
// Define VARLAT_BANK_ARB_WRESP_EN to track store handshakes and route store responses as well.
module varlat_bank_arb #(
  parameter int NumIn          = 4,
  parameter int ReqDataWidth   = 32,
  parameter int RespDataWidth  = 32,
  parameter int MaxOutstanding = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumIn-1:0]                      req_i,
  input  logic [NumIn-1:0]                      wen_i,
  input  logic [NumIn*ReqDataWidth-1:0]         wdata_i,
  output logic [NumIn-1:0]                      gnt_o,
  output logic [NumIn-1:0]                      vld_o,
  output logic [NumIn*RespDataWidth-1:0]        rdata_o,
  output logic                                  req_o,
  output logic                                  wen_o,
  output logic [ReqDataWidth-1:0]               wdata_o,
  input  logic                                  gnt_i,
  input  logic                                  vld_i,
  input  logic [RespDataWidth-1:0]              rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  err_o
);

  localparam int IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  // Handshake: a bank transfer happens in a cycle where req_o and gnt_i are both high;
  // a response is the single cycle vld_i is high, returned in request order.
  logic [IdxW-1:0] rr_q;
  logic [IdxW-1:0] winner;
  logic            any_req;
  logic            full;
  logic            hs;
  logic            track;
  logic            pop;
  logic            fifo_empty;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            err_q;
  logic [IdxW-1:0] id_mem [MaxOutstanding];
  logic [IdxW-1:0] head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // Iterate from the farthest offset down so the nearest requester at/after rr_q wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = NumIn - 1; i >= 0; i--) begin
      if (req_i[(int'(rr_q) + i) % NumIn]) begin
        winner  = IdxW'((int'(rr_q) + i) % NumIn);
        any_req = 1'b1;
      end
    end
  end

  assign full       = (count_q == CntW'(MaxOutstanding));
  assign fifo_empty = (count_q == '0);
  assign req_o      = any_req & ~full;
  assign wen_o      = req_o ? wen_i[winner] : 1'b0;
  assign wdata_o    = req_o ? wdata_i[winner*ReqDataWidth +: ReqDataWidth] : '0;
  assign hs         = req_o & gnt_i;
  assign pop        = vld_i & ~fifo_empty;
  assign head       = id_mem[rd_ptr_q];

`ifdef VARLAT_BANK_ARB_WRESP_EN
  assign track = hs;
`else
  assign track = hs & ~wen_o;
`endif

  always_comb begin
    gnt_o         = '0;
    gnt_o[winner] = hs;
  end

  always_comb begin
    vld_o   = '0;
    rdata_o = '0;
    if (pop) begin
      vld_o[head]                                  = 1'b1;
      rdata_o[head*RespDataWidth +: RespDataWidth] = rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (hs) begin
      rr_q <= (winner == IdxW'(NumIn - 1)) ? '0 : winner + 1'b1;
    end
  end

  // ID storage is not reset: only the pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (track) begin
      id_mem[wr_ptr_q] <= winner;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (track) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({track, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (vld_i && fifo_empty) err_q <= 1'b1;
    end
  end

  assign outstanding_o = count_q;
  assign err_o         = err_q;

endmodule

// File: doc/varlat_bank_arb.md
VARLAT_BANK_ARB -- requirements
Module: varlat_bank_arb

Interface
REQ-001 SHALL have parameter NumIn, default 4, number of requesters sharing one bank port (>=2).
REQ-002 SHALL have parameter ReqDataWidth, default 32, request write-data width.
REQ-003 SHALL have parameter RespDataWidth, default 32, response read-data width.
REQ-004 SHALL have parameter MaxOutstanding, default 4, depth of the response-routing ID FIFO (>=1).
REQ-005 SHALL have one clock, clk_i; reset is asynchronous and active-high, rst_i.
REQ-006 clk_i  input  1  clock, rising edge.
REQ-007 rst_i  input  1  asynchronous active-high reset.
REQ-008 req_i  input  NumIn  per-requester request.
REQ-009 wen_i  input  NumIn  1 store, 0 load.
REQ-010 wdata_i  input  NumIn x ReqDataWidth  per-requester write data.
REQ-011 gnt_o  output  NumIn  per-requester grant, one-hot or zero.
REQ-012 vld_o  output  NumIn  per-requester response valid, one-hot or zero.
REQ-013 rdata_o  output  NumIn x RespDataWidth  per-requester response data.
REQ-014 req_o / wen_o / wdata_o  output  1 / 1 / ReqDataWidth  bank-side request, muxed from winner.
REQ-015 gnt_i  input  1  bank-side grant.
REQ-016 vld_i / rdata_i  input  1 / RespDataWidth  bank-side in-order response.
REQ-017 outstanding_o  output  $clog2(MaxOutstanding+1)  tracked transactions in flight.
REQ-018 err_o  output  1  sticky: response received with empty ID FIFO.

Function
REQ-019 Winner SHALL be first requester with req_i set at or after rr pointer, searching upward with wrap NumIn-1 -> 0.
REQ-020 req_o SHALL equal (|req_i) AND NOT full, combinationally (zero-cycle request path); full means outstanding = MaxOutstanding, regardless of same-cycle vld_i.
REQ-021 wen_o, wdata_o SHALL carry the winner's fields; zero when no request.
REQ-022 gnt_o[winner] SHALL equal req_o AND gnt_i; all other gnt_o bits 0.
REQ-023 Handshake (req_o AND gnt_i) SHALL advance rr pointer to (winner+1) mod NumIn at the next edge; pointer otherwise held.
REQ-024 Tracked handshake SHALL push winner index into ID FIFO; loads always tracked, stores per REQ-035.
REQ-025 vld_i with FIFO non-empty SHALL pop head and drive vld_o[head]=1, rdata_o[head]=rdata_i combinationally; other lanes vld_o 0, rdata_o 0.
REQ-026 Simultaneous push and pop SHALL leave outstanding_o unchanged, FIFO order preserved; pointers wrap mod MaxOutstanding.
REQ-027 vld_i with FIFO empty SHALL be dropped (all vld_o 0) and set err_o at next edge; err_o clears only on reset.
REQ-028 Requests SHALL be stalled (gnt_o 0) while full; no request dropped, requester holds req_i.
REQ-029 outstanding_o SHALL never exceed MaxOutstanding nor underflow.

Reset
REQ-030 rst_i assertion SHALL immediately (asynchronously) set rr pointer 0, FIFO pointers 0, outstanding_o 0, err_o 0.
REQ-031 Combinational outputs SHALL follow REQ-020..025 from reset state (req_o may assert during reset if req_i set).
REQ-032 Reset mid-operation SHALL discard in-flight IDs; later vld_i for them sets err_o per REQ-027.

Configuration
REQ-033 Macro VARLAT_BANK_ARB_WRESP_EN SHALL select store-response tracking.
REQ-034 Defined: store handshakes push IDs; bank returns vld_i for stores, routed as REQ-025.
REQ-035 Undefined: store handshakes do not push, do not count toward full; only loads return vld_i.

Verification
REQ-036 Reset, req_i=4'b1111, gnt_i=1 constant, vld_i=0: grants 0,1,2,3 on cycles 1-4, then req_o=0, outstanding_o=4.
REQ-037 Loads from 2 then 0 granted, vld_i two cycles with rdata_i 0xA5A5A5A5, 0x5A5A5A5A: vld_o=4'b0100 then 4'b0001 with matching rdata_o.
REQ-038 MaxOutstanding=4 full, vld_i=1 and req_i[1]=1 same cycle: gnt_o=0, next cycle outstanding_o=3, gnt_o[1]=1.
REQ-039 vld_i=1 with outstanding_o=0: vld_o=0, err_o=1 next cycle and held until rst_i.
REQ-040 Store from 3 granted: with VARLAT_BANK_ARB_WRESP_EN outstanding_o=1 and later vld_i gives vld_o=4'b1000; without, outstanding_o=0.
REQ-041 rst_i asserted asynchronously with outstanding_o=2: outstanding_o=0, pointer 0 before next edge; stale vld_i sets err_o.
